// File: rtl/regfile_rat.sv
// Architectural register file with per-register busy/producer-tag scoreboard.
// Combinational reads with tag-matched writeback bypass; rename, writeback and flush update state.
module regfile_rat #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREG  = 32,
  parameter int unsigned TAG_W = 5,
  parameter int unsigned NRD   = 2,
  parameter int unsigned NWB   = 2,
  localparam int unsigned IDX_W = $clog2(NREG)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  rn_valid,
  input  logic [IDX_W-1:0]      rn_dest,
  input  logic [TAG_W-1:0]      rn_tag,
  input  logic [NWB-1:0]        wb_valid,
  input  logic [NWB*IDX_W-1:0]  wb_dest,
  input  logic [NWB*TAG_W-1:0]  wb_tag,
  input  logic [NWB*XLEN-1:0]   wb_data,
  input  logic [NRD*IDX_W-1:0]  rd_idx,
  output logic [NRD*XLEN-1:0]   rd_data,
  output logic [NRD-1:0]        rd_busy,
  output logic [NRD*TAG_W-1:0]  rd_tag
);

  logic [XLEN-1:0]  data_q [NREG];
  logic [XLEN-1:0]  data_d [NREG];
  logic [NREG-1:0]  busy_q;
  logic [NREG-1:0]  busy_d;
  logic [TAG_W-1:0] tag_q  [NREG];
  logic [TAG_W-1:0] tag_d  [NREG];

  logic [IDX_W-1:0] wb_dest_a [NWB];
  logic [TAG_W-1:0] wb_tag_a  [NWB];
  logic [XLEN-1:0]  wb_data_a [NWB];

  for (genvar i = 0; i < NWB; i++) begin : g_wb_unpack
    assign wb_dest_a[i] = wb_dest[i*IDX_W +: IDX_W];
    assign wb_tag_a[i]  = wb_tag[i*TAG_W +: TAG_W];
    assign wb_data_a[i] = wb_data[i*XLEN +: XLEN];
  end

  // Next state: writebacks (higher port wins data), then rename, then flush overrides busy/tag.
  always_comb begin
    data_d = data_q;
    busy_d = busy_q;
    tag_d  = tag_q;
    for (int unsigned i = 0; i < NWB; i++) begin
      if (wb_valid[i] && (wb_dest_a[i] != '0)) begin
        data_d[wb_dest_a[i]] = wb_data_a[i];
        if (busy_q[wb_dest_a[i]] && (tag_q[wb_dest_a[i]] == wb_tag_a[i])) begin
          busy_d[wb_dest_a[i]] = 1'b0;
        end
      end
    end
    if (rn_valid && !flush && (rn_dest != '0)) begin
      busy_d[rn_dest] = 1'b1;
      tag_d[rn_dest]  = rn_tag;
    end
    if (flush) begin
      busy_d = '0;
      for (int unsigned k = 0; k < NREG; k++) begin
        tag_d[k] = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
      for (int unsigned k = 0; k < NREG; k++) begin
        data_q[k] <= '0;
        tag_q[k]  <= '0;
      end
    end else begin
      busy_q <= busy_d;
      data_q <= data_d;
      tag_q  <= tag_d;
    end
  end

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [IDX_W-1:0] idx;
    logic [XLEN-1:0]  data_r;
    logic             busy_r;
    logic [TAG_W-1:0] tag_r;

    assign idx = rd_idx[p*IDX_W +: IDX_W];

    // Stored value unless a same-cycle writeback resolves the pending producer.
    always_comb begin
      data_r = data_q[idx];
      busy_r = busy_q[idx];
      tag_r  = busy_q[idx] ? tag_q[idx] : '0;
      for (int unsigned j = 0; j < NWB; j++) begin
        if (wb_valid[j] && (wb_dest_a[j] == idx) && busy_q[idx] &&
            (tag_q[idx] == wb_tag_a[j])) begin
          data_r = wb_data_a[j];
          busy_r = 1'b0;
          tag_r  = '0;
        end
      end
      if (idx == '0) begin
        data_r = '0;
        busy_r = 1'b0;
        tag_r  = '0;
      end
    end

    assign rd_data[p*XLEN +: XLEN]   = data_r;
    assign rd_busy[p]                = busy_r;
    assign rd_tag[p*TAG_W +: TAG_W]  = tag_r;
  end

endmodule

// File: tb/tb_regfile_rat.sv
// Self-checking bench for regfile_rat: directed scenarios plus randomized traffic
// compared against an array-based reference model of the register/scoreboard state.
module tb_regfile_rat;
  localparam int unsigned XLEN  = 32;
  localparam int unsigned NREG  = 32;
  localparam int unsigned TAG_W = 5;
  localparam int unsigned NRD   = 2;
  localparam int unsigned NWB   = 2;
  localparam int unsigned IDX_W = $clog2(NREG);

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 flush;
  logic                 rn_valid;
  logic [IDX_W-1:0]     rn_dest;
  logic [TAG_W-1:0]     rn_tag;
  logic [NWB-1:0]       wb_valid;
  logic [NWB*IDX_W-1:0] wb_dest;
  logic [NWB*TAG_W-1:0] wb_tag;
  logic [NWB*XLEN-1:0]  wb_data;
  logic [NRD*IDX_W-1:0] rd_idx;
  logic [NRD*XLEN-1:0]  rd_data;
  logic [NRD-1:0]       rd_busy;
  logic [NRD*TAG_W-1:0] rd_tag;

  regfile_rat #(.XLEN(XLEN), .NREG(NREG), .TAG_W(TAG_W), .NRD(NRD), .NWB(NWB)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .rn_valid(rn_valid), .rn_dest(rn_dest), .rn_tag(rn_tag),
    .wb_valid(wb_valid), .wb_dest(wb_dest), .wb_tag(wb_tag), .wb_data(wb_data),
    .rd_idx(rd_idx), .rd_data(rd_data), .rd_busy(rd_busy), .rd_tag(rd_tag)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: what each architectural register holds and who it waits for.
  logic [XLEN-1:0]  m_data [NREG];
  bit               m_busy [NREG];
  logic [TAG_W-1:0] m_tag  [NREG];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle();
    rst = 1'b0; flush = 1'b0; rn_valid = 1'b0; rn_dest = '0; rn_tag = '0;
    wb_valid = '0; wb_dest = '0; wb_tag = '0; wb_data = '0; rd_idx = '0;
  endtask

  task automatic set_wb(input int p, input int d, input int t, input logic [XLEN-1:0] v);
    wb_valid[p] = 1'b1;
    wb_dest[p*IDX_W +: IDX_W] = IDX_W'(d);
    wb_tag[p*TAG_W +: TAG_W]  = TAG_W'(t);
    wb_data[p*XLEN +: XLEN]   = v;
  endtask

  task automatic set_rn(input int d, input int t);
    rn_valid = 1'b1; rn_dest = IDX_W'(d); rn_tag = TAG_W'(t);
  endtask

  task automatic set_rd(input int p, input int r);
    rd_idx[p*IDX_W +: IDX_W] = IDX_W'(r);
  endtask

  // Expected read: r0 is hardwired; a busy register whose pending tag is on a wb port reads that value.
  task automatic model_read(input int r, output logic [XLEN-1:0] d, output logic b,
                            output logic [TAG_W-1:0] t);
    d = '0; b = 1'b0; t = '0;
    if (r != 0) begin
      d = m_data[r];
      b = m_busy[r];
      t = m_busy[r] ? m_tag[r] : '0;
      if (m_busy[r]) begin
        for (int j = 0; j < int'(NWB); j++) begin
          if (wb_valid[j] && int'(wb_dest[j*IDX_W +: IDX_W]) == r &&
              wb_tag[j*TAG_W +: TAG_W] == m_tag[r]) begin
            d = wb_data[j*XLEN +: XLEN];
            b = 1'b0;
            t = '0;
          end
        end
      end
    end
  endtask

  task automatic read_chk(input int p, input string nm, input logic [XLEN-1:0] ed,
                          input logic eb, input logic [TAG_W-1:0] et);
    check_eq({nm, ".data"}, 64'(rd_data[p*XLEN +: XLEN]), 64'(ed));
    check_eq({nm, ".busy"}, 64'(rd_busy[p]), 64'(eb));
    check_eq({nm, ".tag"},  64'(rd_tag[p*TAG_W +: TAG_W]), 64'(et));
  endtask

  // Compare all read ports with the model, then clock once and advance the model.
  task automatic cycle();
    logic [XLEN-1:0]  nd [NREG];
    bit               nb [NREG];
    logic [TAG_W-1:0] nt [NREG];
    logic [XLEN-1:0]  ed;
    logic             eb;
    logic [TAG_W-1:0] et;
    int               r;
    int               d;
    #1;
    for (int p = 0; p < int'(NRD); p++) begin
      r = int'(rd_idx[p*IDX_W +: IDX_W]);
      model_read(r, ed, eb, et);
      read_chk(p, $sformatf("rd p%0d r%0d", p, r), ed, eb, et);
    end
    nd = m_data; nb = m_busy; nt = m_tag;
    if (rst) begin
      for (int k = 0; k < int'(NREG); k++) begin
        nd[k] = '0; nb[k] = 1'b0; nt[k] = '0;
      end
    end else begin
      for (int i = 0; i < int'(NWB); i++) begin
        d = int'(wb_dest[i*IDX_W +: IDX_W]);
        if (wb_valid[i] && d != 0) begin
          nd[d] = wb_data[i*XLEN +: XLEN];
          if (m_busy[d] && m_tag[d] == wb_tag[i*TAG_W +: TAG_W]) nb[d] = 1'b0;
        end
      end
      if (rn_valid && !flush && rn_dest != '0) begin
        nb[rn_dest] = 1'b1;
        nt[rn_dest] = rn_tag;
      end
      if (flush) begin
        for (int k = 0; k < int'(NREG); k++) begin
          nb[k] = 1'b0; nt[k] = '0;
        end
      end
    end
    @(posedge clk);
    m_data = nd; m_busy = nb; m_tag = nt;
    #1;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    for (int k = 0; k < int'(NREG); k++) begin
      m_data[k] = '0; m_busy[k] = 1'b0; m_tag[k] = '0;
    end
    @(posedge clk); #1;
    cycle();
    idle();

    // Reset state across every register on both ports, r0 rename ignored.
    for (int r = 0; r < int'(NREG); r++) begin
      set_rd(0, r); set_rd(1, int'(NREG) - 1 - r);
      #1; read_chk(0, $sformatf("reset r%0d", r), '0, 1'b0, '0);
      cycle();
    end
    idle(); set_rn(0, 7); cycle();
    idle(); set_rd(0, 0); #1; read_chk(0, "r0 after rename", '0, 1'b0, '0); cycle();

    // Rename, bypass on matching writeback, then stored value.
    idle(); set_rn(5, 3); cycle();
    idle(); set_rd(0, 5); #1; read_chk(0, "r5 busy", '0, 1'b1, TAG_W'(3)); cycle();
    idle(); set_rd(0, 5); set_wb(0, 5, 3, 32'hDEADBEEF);
    #1; read_chk(0, "r5 bypass", 32'hDEADBEEF, 1'b0, '0); cycle();
    idle(); set_rd(0, 5); #1; read_chk(0, "r5 stored", 32'hDEADBEEF, 1'b0, '0); cycle();

    // Stale tag writes data only.
    idle(); set_rn(5, 3); cycle();
    idle(); set_rn(5, 9); cycle();
    idle(); set_wb(1, 5, 3, 32'h11); cycle();
    idle(); set_rd(1, 5); #1; read_chk(1, "r5 stale wb", 32'h11, 1'b1, TAG_W'(9)); cycle();
    idle(); set_wb(0, 5, 9, 32'h22); cycle();
    idle(); set_rd(1, 5); #1; read_chk(1, "r5 final wb", 32'h22, 1'b0, '0); cycle();

    // Two ports to the same register: highest port wins.
    idle(); set_rn(6, 2); cycle();
    idle(); set_wb(0, 6, 2, 32'hA); set_wb(1, 6, 2, 32'hB); set_rd(0, 6); set_rd(1, 6);
    #1; read_chk(0, "r6 dual bypass", 32'hB, 1'b0, '0); cycle();
    idle(); set_rd(0, 6); #1; read_chk(0, "r6 dual stored", 32'hB, 1'b0, '0); cycle();

    // Rename beats a same-cycle matching writeback.
    idle(); set_rn(8, 4); cycle();
    idle(); set_rn(8, 12); set_wb(0, 8, 4, 32'h55); cycle();
    idle(); set_rd(0, 8); #1; read_chk(0, "r8 rename wins", 32'h55, 1'b1, TAG_W'(12)); cycle();

    // Flush clears busy, keeps writeback data, ignores rename.
    idle(); set_rn(1, 1); cycle();
    idle(); set_rn(2, 2); cycle();
    idle(); set_rn(3, 3); cycle();
    idle(); flush = 1'b1; set_wb(0, 2, 30, 32'h77); set_rn(4, 5); set_rd(0, 1); set_rd(1, 3);
    #1; read_chk(0, "r1 flush cycle", '0, 1'b1, TAG_W'(1)); cycle();
    for (int r = 1; r <= 4; r++) begin
      idle(); set_rd(0, r);
      #1; read_chk(0, $sformatf("post flush r%0d", r), (r == 2) ? 32'h77 : 32'h0, 1'b0, '0);
      cycle();
    end

    // Synchronous reset mid-stream overrides rename and writeback.
    idle(); set_rn(9, 6); cycle();
    idle(); rst = 1'b1; set_rn(10, 1); set_wb(0, 2, 0, 32'h99); cycle();
    for (int r = 0; r < 12; r++) begin
      idle(); set_rd(0, r); set_rd(1, r + 12);
      #1; read_chk(0, $sformatf("mid reset r%0d", r), '0, 1'b0, '0); cycle();
    end

    // Randomized traffic on a narrow register/tag range for frequent collisions.
    for (int n = 0; n < 3000; n++) begin
      idle();
      rst   = ($urandom_range(0, 199) == 0);
      flush = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 1) == 1) set_rn(int'($urandom_range(0, 7)), int'($urandom_range(0, 3)));
      for (int p = 0; p < int'(NWB); p++) begin
        if ($urandom_range(0, 2) != 0)
          set_wb(p, int'($urandom_range(0, 7)), int'($urandom_range(0, 3)), XLEN'($urandom));
      end
      for (int p = 0; p < int'(NRD); p++) set_rd(p, int'($urandom_range(0, 7)));
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
